// File: rtl/adventure_pkg.sv
// rtl/adventure_pkg.sv - shared room encoding and button constants for the room FSM
package adventure_pkg;

    localparam int ROOM_W = 7;

    localparam int IDX_CAVE      = 0;
    localparam int IDX_TUNNEL    = 1;
    localparam int IDX_RIVER     = 2;
    localparam int IDX_STASH     = 3;
    localparam int IDX_DEN       = 4;
    localparam int IDX_VICTORY   = 5;
    localparam int IDX_GRAVEYARD = 6;

    // One-hot encoding so the state register is directly the room output.
    typedef enum logic [ROOM_W-1:0] {
        ROOM_CAVE      = ROOM_W'(1 << IDX_CAVE),
        ROOM_TUNNEL    = ROOM_W'(1 << IDX_TUNNEL),
        ROOM_RIVER     = ROOM_W'(1 << IDX_RIVER),
        ROOM_STASH     = ROOM_W'(1 << IDX_STASH),
        ROOM_DEN       = ROOM_W'(1 << IDX_DEN),
        ROOM_VICTORY   = ROOM_W'(1 << IDX_VICTORY),
        ROOM_GRAVEYARD = ROOM_W'(1 << IDX_GRAVEYARD)
    } room_t;

    // Button vector order is {n, s, e, w}.
    localparam logic [3:0] BTN_N = 4'b1000;
    localparam logic [3:0] BTN_S = 4'b0100;
    localparam logic [3:0] BTN_E = 4'b0010;
    localparam logic [3:0] BTN_W = 4'b0001;

    // True when exactly one press bit is set.
    function automatic logic single_press(input logic [3:0] p);
        return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/adventure_room_fsm_if.sv
// rtl/adventure_room_fsm_if.sv - player buttons, sword handshake and room status bundle
interface adventure_room_fsm_if #(
    parameter int MOVE_W = 8
);
    import adventure_pkg::*;

    logic              n;
    logic              s;
    logic              e;
    logic              w;
    logic              k;
    logic              sw;
    logic [ROOM_W-1:0] room;
    logic              win;
    logic              dead;
    logic [MOVE_W-1:0] moves;

    // Player / sword-latch side.
    modport master (
        output n, s, e, w, k,
        input  sw, room, win, dead, moves
    );

    // Room FSM side.
    modport slave (
        input  n, s, e, w, k,
        output sw, room, win, dead, moves
    );

endinterface

// File: rtl/dir_edge_detect.sv
// rtl/dir_edge_detect.sv - rising-edge press detection with single-press qualification
module dir_edge_detect
    import adventure_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic [3:0] press,
    output logic       press_valid
);

    logic [3:0] prev_q;

    // Previous-level register; reset to all-ones so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 4'b1111;
        end else begin
            prev_q <= btn;
        end
    end

    assign press       = btn & ~prev_q;
    assign press_valid = single_press(press);

endmodule

// File: rtl/adventure_room_fsm.sv
// rtl/adventure_room_fsm.sv - room navigation FSM with saturating move counter and end flags
module adventure_room_fsm
    import adventure_pkg::*;
#(
    parameter int MOVE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    adventure_room_fsm_if.slave  bus
);

    room_t             state_q;
    logic [MOVE_W-1:0] moves_q;
    logic [3:0]        press;
    logic              press_valid;

    dir_edge_detect u_edge (
        .clk         (clk),
        .reset       (reset),
        .btn         ({bus.n, bus.s, bus.e, bus.w}),
        .press       (press),
        .press_valid (press_valid)
    );

    function automatic logic [MOVE_W-1:0] sat_inc(input logic [MOVE_W-1:0] v);
        return (v == {MOVE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Room transitions and move counting; only accepted button moves bump the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ROOM_CAVE;
            moves_q <= '0;
        end else begin
            case (state_q)
                ROOM_CAVE: begin
                    if (press_valid && press == BTN_E) begin
                        state_q <= ROOM_TUNNEL;
                        moves_q <= sat_inc(moves_q);
                    end
                end
                ROOM_TUNNEL: begin
                    if (press_valid && press == BTN_S) begin
                        state_q <= ROOM_RIVER;
                        moves_q <= sat_inc(moves_q);
                    end else if (press_valid && press == BTN_W) begin
                        state_q <= ROOM_CAVE;
                        moves_q <= sat_inc(moves_q);
                    end
                end
                ROOM_RIVER: begin
                    if (press_valid && press == BTN_W) begin
                        state_q <= ROOM_STASH;
                        moves_q <= sat_inc(moves_q);
                    end else if (press_valid && press == BTN_E) begin
                        state_q <= ROOM_DEN;
                        moves_q <= sat_inc(moves_q);
                    end
                end
                ROOM_STASH: begin
                    if (press_valid && press == BTN_E) begin
                        state_q <= ROOM_RIVER;
                        moves_q <= sat_inc(moves_q);
                    end
                end
                // The encounter resolves after exactly one cycle; the sword is sampled here.
                ROOM_DEN: begin
                    state_q <= bus.k ? ROOM_VICTORY : ROOM_GRAVEYARD;
                end
                ROOM_VICTORY, ROOM_GRAVEYARD: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ROOM_CAVE;
                end
            endcase
        end
    end

    assign bus.room  = state_q;
    assign bus.sw    = state_q[IDX_STASH];
    assign bus.win   = state_q[IDX_VICTORY];
    assign bus.dead  = state_q[IDX_GRAVEYARD];
    assign bus.moves = moves_q;

endmodule
